// File: rtl/port_io_pkg.sv
// Shared definitions for the port I/O front end: FSM encoding and default data width.
package port_io_pkg;

    localparam int unsigned WidthDefault = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StGap   = 2'd2
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, no bypass: a pushed byte appears at head a cycle later.
module sync_fifo
    import port_io_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW:0]    r_count;

    // Storage needs no reset; occupancy tracking below decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = (r_count == (PtrW + 1)'(DEPTH));
    assign empty     = (r_count == '0);

endmodule

// File: rtl/port_io_ctrl.sv
// Port I/O front end: round-robin intake of two requesters into a FIFO, replay as
// fixed-length port_write pulses with an idle gap, and change detection on port_out.
module port_io_ctrl
    import port_io_pkg::*;
#(
    parameter int unsigned WIDTH     = WidthDefault,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PULSE_LEN = 10,
    parameter int unsigned GAP_LEN   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [WIDTH-1:0]         req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [WIDTH-1:0]         req1_data,
    output logic                     req1_ready,
    output logic                     port_write,
    output logic [WIDTH-1:0]         port_in,
    input  logic [WIDTH-1:0]         port_out,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int unsigned MaxLen = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_LEN - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_LEN - 1);

    logic                   r_prio;
    logic                   w_grant1;
    logic                   w_push;
    logic [WIDTH-1:0]       w_push_data;
    logic                   w_pop;
    logic [WIDTH-1:0]       w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CntW-1:0]        r_cnt;
    logic [CntW-1:0]        w_cnt_nxt;
    logic                   r_port_write;
    logic                   w_port_write_nxt;
    logic [WIDTH-1:0]       r_port_in;
    logic [WIDTH-1:0]       w_port_in_nxt;
    logic [WIDTH-1:0]       r_out_data;
    logic                   r_out_valid;

    // Arbiter: preferred requester wins if valid, otherwise the other one is granted.
    always_comb begin
        w_grant1    = r_prio ? req1_valid : !req0_valid;
        req0_ready  = !w_full && !w_grant1;
        req1_ready  = !w_full && w_grant1;
        w_push      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        w_push_data = w_grant1 ? req1_data : req0_data;
    end

    // Priority moves to the requester that was not served; held when nothing is pushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 1'b0;
        end else if (w_push) begin
            r_prio <= !w_grant1;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Replay FSM next state: pop only when leaving IDLE so port_in is stable during a pulse.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_port_write_nxt = r_port_write;
        w_port_in_nxt    = r_port_in;
        w_pop            = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop            = 1'b1;
                    w_port_in_nxt    = w_head;
                    w_port_write_nxt = 1'b1;
                    w_cnt_nxt        = PulseLoad;
                    w_state_nxt      = StDrive;
                end
            end
            StDrive: begin
                if (r_cnt == '0) begin
                    w_port_write_nxt = 1'b0;
                    w_cnt_nxt        = GapLoad;
                    w_state_nxt      = StGap;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StGap: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt      = StIdle;
                w_port_write_nxt = 1'b0;
            end
        endcase
    end

    // Replay FSM state and registered port drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_port_write <= 1'b0;
            r_port_in    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_port_write <= w_port_write_nxt;
            r_port_in    <= w_port_in_nxt;
        end
    end

    // Output monitor: register port_out and pulse when the registered value changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_data  <= port_out;
            r_out_valid <= (port_out != r_out_data);
        end
    end

    assign port_write = r_port_write;
    assign port_in    = r_port_in;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign fifo_count = w_count;
    assign busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: doc/port_io_ctrl.md
Name: port_io_ctrl

Overview:
- Front end for the computer's single input port (port_write/port_in) and its output port (port_out).
- Arbitrates two host-side requesters round-robin into a small FIFO.
- Replays queued bytes to the computer as fixed-length port_write pulses with a guaranteed idle gap between them.
- Registers port_out and emits a one-cycle strobe whenever the computer changes its output.

Parameters:
WIDTH, 8, data width of port_in/port_out and requester data
DEPTH, 4, FIFO entries; power of two, >= 2
PULSE_LEN, 10, cycles port_write is held high per byte; >= 1
GAP_LEN, 4, cycles port_write is held low after each pulse; >= 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req0_valid  input  1  requester 0 has a byte
req0_data  input  WIDTH  requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready
req1_valid  input  1  requester 1 has a byte
req1_data  input  WIDTH  requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle when valid&ready
port_write  output  1  to computer: write strobe
port_in  output  WIDTH  to computer: input byte
port_out  input  WIDTH  from computer: output byte
out_data  output  WIDTH  registered port_out
out_valid  output  1  one-cycle pulse when out_data changes
fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy
busy  output  1  FSM not in IDLE, or FIFO non-empty

Behaviour:
- Reset (reset=0, async):
  - port_write=0, port_in=0, out_data=0, out_valid=0, fifo_count=0.
  - FSM=IDLE; round-robin priority=req0.
  - Applies immediately, including mid-pulse.
  - Queued bytes are discarded.
- Arbitration:
  - Priority pointer selects the preferred requester.
  - grant = preferred if it is valid, else the other.
  - reqN_ready = (fifo_count<DEPTH) && grant==N. Computed combinationally from registered count and valids.
  - At most one push per cycle.
  - After an accepted push, the pointer moves to the non-accepted requester.
  - Full FIFO: both ready=0; pointer unchanged.
- FIFO:
  - Push at clock edge on handshake.
  - Pop only on the IDLE->DRIVE transition.
  - Push and pop in the same cycle: count unchanged.
  - No bypass: a byte pushed at edge t is visible to the FSM from cycle t+1.
  - Pointers wrap modulo DEPTH.
- FSM, states IDLE, DRIVE, GAP:
  - IDLE:
    - FIFO non-empty -> at next edge, port_in<=head, pop, port_write<=1, counter<=PULSE_LEN-1, go to DRIVE.
    - Otherwise stay in IDLE.
  - DRIVE:
    - port_write=1; counter decrements each cycle.
    - At counter==0 -> port_write<=0, counter<=GAP_LEN-1, go to GAP.
  - GAP:
    - port_write=0; counter decrements each cycle.
    - At 0 -> go to IDLE.
  - port_in holds its value from pop until the next pop. It is never changed while port_write=1.
- Timing:
  - Latency: push at edge t into an empty FIFO in IDLE -> port_write high from edge t+1, for exactly PULSE_LEN cycles.
  - Back-to-back queued bytes start PULSE_LEN+GAP_LEN+1 cycles apart (IDLE lasts one cycle).
- Output monitor:
  - out_data<=port_out every edge.
  - out_valid<=1 for one cycle when the newly registered value differs from the previous out_data.
  - Constant port_out produces no pulses.
  - A change on the first edge after reset release (0 -> X) pulses.

Decomposition:
- Shared package port_io_pkg:
  - FSM state encoding constants (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2).
  - Default WIDTH.
- One sub-module: sync_fifo.
  - Parameters WIDTH, DEPTH.
  - Ports: push, push_data, pop, head_data, count, full, empty.
  - Same clk/async active-low reset.
- Arbiter, FSM and output monitor stay in port_io_ctrl.

Test Plan (PULSE_LEN=10, GAP_LEN=4, DEPTH=4):
1. req0 sends 10 at edge t, FIFO empty -> req0_ready=1; port_in=10 and port_write=1 from edge t+1 to t+11; port_write=0 for 4 cycles; fifo_count returns to 0.
2. req0=10 and req1=5 valid in the same cycle after reset -> req0 accepted first, req1 next cycle; port_in sequence 10 then 5; rising edges of port_write 15 cycles apart.
3. Both requesters hold valid continuously with incrementing data -> accepts alternate 0,1,0,1; fifo_count saturates at 4 with both ready=0; after each pop exactly one push, still alternating.
4. Assert reset=0 in the 5th DRIVE cycle with 3 bytes queued -> port_write=0 and fifo_count=0 without waiting for an edge; after release, no port_write activity until a new push.
5. port_out: 0 for 5 cycles, then 55, held 6 cycles, then 56 -> out_valid single pulses one edge after each change; out_data=55 then 56; no other pulses.
6. Push while FIFO is full and the FSM pops in the same cycle -> push refused (ready=0 that cycle), accepted the following cycle; no byte lost or duplicated in the port_in sequence.
